// File: rtl/uart_pkg.sv
// Constants shared by the UART receive and transmit paths: frame shape,
// default bit timing and the receiver FSM state encoding.
package uart_pkg;

  // 100 MHz system clock / 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 10416;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  typedef logic [DATA_BITS-1:0] rx_byte_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through circular FIFO for received bytes. Pointers carry
// one extra MSB so that full and empty can be told apart.
module rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                 (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  assign wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
  assign rdPtr_d = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q[AW-1:0]] <= din;
    end
  end

  // Storage is not reset; the head reads as zero whenever nothing is queued.
  assign dout = empty ? '0 : mem_q[rdPtr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver: synchronizes the RX pin, deserializes frames, checks the
// stop bit and queues good bytes in a small FWFT FIFO for downstream readers.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       signal_in,
  input  logic       rd_en,
  output logic [7:0] ascii_out,
  output logic       data_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_BIT_LAST = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA_BIT = IW'(DATA_BITS - 1);

  logic          rxSync1_q, rxSync2_q;
  logic          rxS;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] bitCnt_q, bitCnt_d;
  logic [IW-1:0] bitIdx_q, bitIdx_d;
  rx_byte_t      shift_q, shift_d;
  logic          frameErr_q, frameErr_d;
  logic          overrun_q, overrun_d;
  logic          pushByte;
  logic          fifoEmpty, fifoFull;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
    end else begin
      rxSync1_q <= signal_in;
      rxSync2_q <= rxSync1_q;
    end
  end

  assign rxS = rxSync2_q;

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q + 1'b1;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    pushByte   = 1'b0;
    frameErr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bitCnt_d = '0;
        if (!rxS) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Re-check mid start bit; a line already high again was only a glitch.
        if (bitCnt_q == HALF_BIT_LAST) begin
          bitCnt_d = '0;
          bitIdx_d = '0;
          state_d  = rxS ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bitCnt_q == FULL_BIT_LAST) begin
          bitCnt_d = '0;
          shift_d  = {rxS, shift_q[DATA_BITS-1:1]};
          if (bitIdx_q == LAST_DATA_BIT) begin
            state_d = ST_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bitCnt_q == FULL_BIT_LAST) begin
          bitCnt_d = '0;
          if (rxS == STOP_LEVEL) begin
            pushByte = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // A held-low line must not be taken for a stream of new start bits.
        bitCnt_d = '0;
        if (rxS) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        bitCnt_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  assign overrun_d = pushByte && fifoFull && !(rd_en && data_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushByte),
    .din   (shift_d),
    .pop   (rd_en),
    .dout  (ascii_out),
    .empty (fifoEmpty),
    .full  (fifoFull)
  );

  assign data_ready = !fifoEmpty;
  assign frame_err  = frameErr_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed and randomized bench for uart_rx_buffer: a serializer drives 8N1
// frames and a queue model of the receive FIFO supplies the expected bytes.
module tb_uart_rx_buffer;

  localparam int CPB        = 16;
  localparam int DEPTH      = 4;
  localparam int FRAME_CLKS = 10 * CPB;
  // Line edge -> synchronizer (2) -> IDLE sees it (1) -> half bit -> 9 full bits.
  localparam int PUSH_LAT   = 3 + CPB/2 + 9*CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       signal_in = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] ascii_out;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;

  int   cyc = 0;
  int   lastRiseCyc = -1;
  int   lastFeCyc = -1;
  int   feCount = 0;
  int   ovCount = 0;
  logic prevDr = 1'b0;

  logic [7:0] model [$];

  uart_rx_buffer #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .signal_in  (signal_in),
    .rd_en      (rd_en),
    .ascii_out  (ascii_out),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and edge recorder, sampled on the inactive edge.
  always @(negedge clk) begin
    prevDr <= data_ready;
    if (data_ready && !prevDr) lastRiseCyc <= cyc;
    if (frame_err) begin
      feCount   <= feCount + 1;
      lastFeCyc <= cyc;
    end
    if (overrun) ovCount <= ovCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Serializes one 8N1 frame, LSB first; the line is left at the stop level.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               output int startCyc);
    startCyc  = cyc;
    signal_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      signal_in = data[i];
      repeat (CPB) @(negedge clk);
    end
    signal_in = stopBit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idleLine(input int n);
    signal_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic popByte();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic waitReady(input int maxCycles, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < maxCycles; k++) begin
      if (data_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drainModel(input string tag);
    while (model.size() > 0) begin
      checkOutput({tag, "_ready"}, data_ready, 1);
      checkOutput({tag, "_byte"}, ascii_out, model.pop_front());
      popByte();
    end
    checkOutput({tag, "_empty"}, data_ready, 0);
  endtask

  initial begin
    int         sc;
    bit         ok;
    int         feBase, ovBase, expOv;
    logic [7:0] b;
    logic [7:0] stream [20];

    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", data_ready, 0);
    checkOutput("rst_ascii", ascii_out, 8'h00);
    checkOutput("rst_ferr", frame_err, 0);
    checkOutput("rst_ovr", overrun, 0);
    reset = 1'b1;
    idleLine(4);

    // Single frame and its push latency.
    applyStimulus(8'h41, 1'b1, sc);
    checkOutput("a_rise_cyc", lastRiseCyc, sc + PUSH_LAT);
    checkOutput("a_ready", data_ready, 1);
    checkOutput("a_byte", ascii_out, 8'h41);
    popByte();
    checkOutput("a_popped", data_ready, 0);

    // Bad stop bit followed by a long break, then a good frame.
    feBase = feCount;
    applyStimulus(8'h55, 1'b0, sc);
    checkOutput("fe_cyc", lastFeCyc, sc + PUSH_LAT);
    checkOutput("fe_nopush", data_ready, 0);
    repeat (40*CPB) @(negedge clk);
    checkOutput("brk_fe_count", feCount - feBase, 1);
    checkOutput("brk_nopush", data_ready, 0);
    idleLine(2*CPB);
    applyStimulus(8'h30, 1'b1, sc);
    idleLine(CPB);
    model.push_back(8'h30);
    drainModel("after_brk");

    // Short low glitch on an idle line.
    feBase = feCount;
    ovBase = ovCount;
    signal_in = 1'b0;
    repeat (3) @(negedge clk);
    idleLine(2*FRAME_CLKS);
    checkOutput("glitch_ready", data_ready, 0);
    checkOutput("glitch_fe", feCount - feBase, 0);
    checkOutput("glitch_ovr", ovCount - ovBase, 0);

    // Five back-to-back frames into a four-entry FIFO.
    ovBase = ovCount;
    expOv = 0;
    for (int k = 0; k < 5; k++) begin
      b = 8'(8'h31 + k);
      applyStimulus(b, 1'b1, sc);
      if (model.size() < DEPTH) model.push_back(b);
      else expOv++;
    end
    idleLine(CPB);
    checkOutput("ovr_count", ovCount - ovBase, expOv);
    drainModel("ovr");

    // Full FIFO with a pop landing exactly on the push edge of 0x36.
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'(8'h31 + k);
      applyStimulus(b, 1'b1, sc);
      model.push_back(b);
    end
    ovBase = ovCount;
    fork
      applyStimulus(8'h36, 1'b1, sc);
      begin
        repeat (PUSH_LAT - 1) @(negedge clk);
        checkOutput("full_flag", data_ready, 1);
        checkOutput("full_head", ascii_out, model[0]);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    void'(model.pop_front());
    model.push_back(8'h36);
    idleLine(CPB);
    checkOutput("pp_ovr", ovCount - ovBase, 0);
    drainModel("pp");

    // Reset in the middle of a frame.
    fork
      applyStimulus(8'h7E, 1'b1, sc);
      begin
        repeat (60) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready", data_ready, 0);
      end
    join
    idleLine(2*FRAME_CLKS);
    for (int k = 0; k < 2*DEPTH && data_ready; k++) popByte();
    applyStimulus(8'h7E, 1'b1, sc);
    idleLine(CPB);
    model.push_back(8'h7E);
    drainModel("post_rst");

    // Random loopback stream, consumed as it arrives.
    for (int i = 0; i < 20; i++) stream[i] = 8'($urandom_range(0, 255));
    feBase = feCount;
    ovBase = ovCount;
    fork
      for (int i = 0; i < 20; i++) applyStimulus(stream[i], 1'b1, sc);
      for (int j = 0; j < 20; j++) begin
        waitReady(3*FRAME_CLKS, ok);
        checkOutput("lb_timeout", ok, 1);
        if (ok) begin
          checkOutput("lb_byte", ascii_out, stream[j]);
          popByte();
        end
      end
    join
    idleLine(CPB);
    checkOutput("lb_empty", data_ready, 0);
    checkOutput("lb_fe", feCount - feBase, 0);
    checkOutput("lb_ovr", ovCount - ovBase, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
